// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared types and constants for the PS/2 key event decoder.
// Scan-code prefixes, the queued event word and the parser states.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        P_NORM,
        P_EXT,
        P_BRK,
        P_EXTBRK
    } parse_st_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Decoded key event stream: valid/ready handshake plus head fields.
// The decoder drives it as master; the consumer uses the slave view.
interface ps2_key_event_decoder_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break,
        output evt_ready
    );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// The head word is read straight from storage at the read pointer.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still accepts a write when the head leaves this cycle.
    assign do_rd = rd_ready & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Drains PS/2 set-2 bytes, decodes make/break/extended sequences
// and queues key events; also tracks the held key and press count.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_WIDTH     = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [7:0]           ps2_data,
    input  logic                 ps2_ready,
    input  logic                 ps2_overflow,
    output logic                 ps2_nextdata_n,
    ps2_key_event_decoder_if.master evt,
    output logic                 held_valid,
    output logic [7:0]           held_code,
    output logic                 held_ext,
    output logic [CNT_WIDTH-1:0] press_cnt,
    output logic                 evt_overflow,
    input  logic                 clr_overflow,
    output logic                 src_overflow
);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_POP  = 2'd1;
    localparam logic [1:0] F_GAP  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0] f_st;
    logic [7:0] byte_r;
    logic       byte_v;

    // The GAP cycle lets ps2_ready/ps2_data settle after the pop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            f_st           <= F_IDLE;
            byte_r         <= '0;
            byte_v         <= 1'b0;
            ps2_nextdata_n <= 1'b1;
        end else begin
            byte_v         <= 1'b0;
            ps2_nextdata_n <= 1'b1;
            unique case (f_st)
                F_IDLE: begin
                    if (ps2_ready) begin
                        byte_r         <= ps2_data;
                        byte_v         <= 1'b1;
                        ps2_nextdata_n <= 1'b0;
                        f_st           <= F_POP;
                    end
                end
                F_POP:   f_st <= F_GAP;
                F_GAP:   f_st <= F_IDLE;
                default: f_st <= F_IDLE;
            endcase
        end
    end

    parse_st_e p_st;
    parse_st_e p_nxt;
    logic      is_make;
    logic      is_brk;
    logic      cur_ext;
    logic      pfx_brk;
    logic      pfx_ext;

    assign pfx_brk = (byte_r == PS2_BREAK);
    assign pfx_ext = (byte_r == PS2_EXT);

    always_comb begin
        p_nxt   = p_st;
        is_make = 1'b0;
        is_brk  = 1'b0;
        cur_ext = 1'b0;
        if (byte_v) begin
            unique case (p_st)
                P_NORM: begin
                    unique case (1'b1)
                        pfx_ext: p_nxt = P_EXT;
                        pfx_brk: p_nxt = P_BRK;
                        default: is_make = 1'b1;
                    endcase
                end
                P_EXT: begin
                    unique case (1'b1)
                        pfx_brk: p_nxt = P_EXTBRK;
                        pfx_ext: p_nxt = P_EXT;
                        default: begin
                            is_make = 1'b1;
                            cur_ext = 1'b1;
                            p_nxt   = P_NORM;
                        end
                    endcase
                end
                P_BRK: begin
                    if (!is_prefix(byte_r)) begin
                        is_brk = 1'b1;
                        p_nxt  = P_NORM;
                    end
                end
                P_EXTBRK: begin
                    if (!is_prefix(byte_r)) begin
                        is_brk  = 1'b1;
                        cur_ext = 1'b1;
                        p_nxt   = P_NORM;
                    end
                end
                default: p_nxt = P_NORM;
            endcase
        end
    end

    logic     same_key;
    logic     new_press;
    logic     evt_push;
    key_evt_t evt_word;

    assign same_key  = held_valid &&
                       ({cur_ext, byte_r} == {held_ext, held_code});
    assign new_press = is_make && !((FILTER_REPEAT != 0) && same_key);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            p_st       <= P_NORM;
            evt_push   <= 1'b0;
            evt_word   <= '0;
            held_valid <= 1'b0;
            held_code  <= '0;
            held_ext   <= 1'b0;
            press_cnt  <= '0;
        end else begin
            p_st     <= p_nxt;
            evt_push <= new_press || is_brk;
            evt_word <= '{brk: is_brk, ext: cur_ext, code: byte_r};
            if (new_press) begin
                held_valid <= 1'b1;
                held_code  <= byte_r;
                held_ext   <= cur_ext;
                press_cnt  <= press_cnt + CNT_ONE;
            end else if (is_brk && same_key) begin
                held_valid <= 1'b0;
            end
        end
    end

    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_drop;
    key_evt_t head;

    sync_fifo #(
        .WIDTH ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (evt_push),
        .wr_data  (evt_word),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_ready (evt.evt_ready),
        .rd_data  (head)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_code  = head.code;
    assign evt.evt_ext   = head.ext;
    assign evt.evt_break = head.brk;

    assign fifo_drop = evt_push & fifo_full & ~evt.evt_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evt_overflow <= 1'b0;
            src_overflow <= 1'b0;
        end else begin
            if (clr_overflow) begin
                evt_overflow <= 1'b0;
                src_overflow <= 1'b0;
            end else begin
                if (fifo_drop)    evt_overflow <= 1'b1;
                if (ps2_overflow) src_overflow <= 1'b1;
            end
        end
    end

endmodule
